// File: rtl/cla_addsub_pipe_pkg.sv
// Shared opcodes and saturation limits for the pipelined CLA add/sub unit.
package cla_pkg;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_ADDS = 2'b10;
    localparam logic [1:0] OP_SUBS = 2'b11;

    // Largest positive two's complement value of a w-bit word (0 then all ones).
    function automatic logic [63:0] sat_max(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    // Most negative two's complement value of a w-bit word (1 then all zeros).
    function automatic logic [63:0] sat_min(input int w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/cla_addsub_pipe_group.sv
// Combinational BLK-bit carry-lookahead group: every internal carry is formed
// directly from the bit generate/propagate terms and the group carry-in.
module cla_group #(
    parameter int BLK = 3
) (
    input  logic [BLK-1:0] x,
    input  logic [BLK-1:0] y,
    input  logic           cin,
    output logic [BLK-1:0] sum,
    output logic           cout,
    output logic           p,
    output logic           g
);

    logic [BLK-1:0] pbit;
    logic [BLK-1:0] gbit;
    logic [BLK:0]   c;

    assign pbit = x ^ y;
    assign gbit = x & y;
    assign c[0] = cin;

    // Carry into bit gi+1: OR of each lower generate propagated up to gi,
    // plus the carry-in propagated through every bit 0..gi.
    for (genvar gi = 0; gi < BLK; gi++) begin : cbit
        logic [gi:0] term;
        for (genvar gj = 0; gj <= gi; gj++) begin : t
            if (gj == gi) begin : own
                assign term[gj] = gbit[gj];
            end else begin : prop
                assign term[gj] = gbit[gj] & (&pbit[gi:gj+1]);
            end
        end
        assign c[gi+1] = (|term) | ((&pbit[gi:0]) & cin);
    end

    assign sum  = pbit ^ c[BLK-1:0];
    assign cout = c[BLK];
    assign p    = &pbit;
    assign g    = |cbit[BLK-1].term;

endmodule

// File: rtl/cla_addsub_pipe.sv
// Pipelined carry-lookahead adder/subtractor with one stage per lookahead
// group, valid/ready streaming, optional signed saturation and a zero flag.
module cla_addsub_pipe
    import cla_pkg::*;
#(
    parameter int WIDTH  = 15,
    parameter int BLK    = 3,
    parameter int SAT_EN = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NGRP = WIDTH / BLK;
    localparam int LAST = NGRP - 1;
    localparam logic [WIDTH-1:0] RES_MAX = WIDTH'(sat_max(WIDTH));
    localparam logic [WIDTH-1:0] RES_MIN = WIDTH'(sat_min(WIDTH));

    logic             adv;
    logic [WIDTH-1:0] bx_in;

    // Whole pipe moves together whenever the output slot is free or draining.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Subtract becomes A + ~B + 1; the +1 enters as the group-0 carry-in.
    assign bx_in = op[0] ? ~b : b;

    for (genvar gi = 0; gi < NGRP; gi++) begin : stg
        // Operand bits above this stage's group still waiting to be summed.
        localparam int UPW = WIDTH - (gi + 1) * BLK;

        logic [BLK-1:0]         gx;
        logic [BLK-1:0]         gy;
        logic [BLK-1:0]         gsum;
        logic                   gcin;
        logic                   gcout;
        logic                   gp;
        logic                   gg;
        logic [1:0]             src_op;
        logic                   src_v;
        logic [(gi+1)*BLK-1:0]  r_next;
        logic [(gi+1)*BLK-1:0]  r_reg;
        logic                   c_reg;
        logic [1:0]             op_reg;
        logic                   v_reg;
        logic                   unused_pg;

        if (gi == 0) begin : src
            assign gx     = a[BLK-1:0];
            assign gy     = bx_in[BLK-1:0];
            assign gcin   = op[0];
            assign src_op = op;
            assign src_v  = in_valid;
            assign r_next = gsum;
        end else begin : src
            assign gx     = stg[gi-1].up.ahi_reg[BLK-1:0];
            assign gy     = stg[gi-1].up.bhi_reg[BLK-1:0];
            assign gcin   = stg[gi-1].c_reg;
            assign src_op = stg[gi-1].op_reg;
            assign src_v  = stg[gi-1].v_reg;
            assign r_next = {gsum, stg[gi-1].r_reg};
        end

        cla_group #(
            .BLK (BLK)
        ) u_grp (
            .x    (gx),
            .y    (gy),
            .cin  (gcin),
            .sum  (gsum),
            .cout (gcout),
            .p    (gp),
            .g    (gg)
        );

        // Block P/G are spare: the stage carry is the group's own lookahead cout.
        assign unused_pg = gp ^ gg;

        // Stage register: accumulated low result bits, carry into the next
        // group, opcode and valid; bubbles shift exactly like data.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_reg  <= '0;
                c_reg  <= 1'b0;
                op_reg <= 2'b00;
                v_reg  <= 1'b0;
            end else if (adv) begin
                r_reg  <= r_next;
                c_reg  <= gcout;
                op_reg <= src_op;
                v_reg  <= src_v;
            end
        end

        if (UPW > 0) begin : up
            logic [UPW-1:0] ahi_src;
            logic [UPW-1:0] bhi_src;
            logic [UPW-1:0] ahi_reg;
            logic [UPW-1:0] bhi_reg;

            if (gi == 0) begin : hsrc
                assign ahi_src = a[WIDTH-1:BLK];
                assign bhi_src = bx_in[WIDTH-1:BLK];
            end else begin : hsrc
                assign ahi_src = stg[gi-1].up.ahi_reg[UPW+BLK-1:BLK];
                assign bhi_src = stg[gi-1].up.bhi_reg[UPW+BLK-1:BLK];
            end

            // Carry the not-yet-summed operand bits forward to later groups.
            always_ff @(posedge clk) begin
                if (rst) begin
                    ahi_reg <= '0;
                    bhi_reg <= '0;
                end else if (adv) begin
                    ahi_reg <= ahi_src;
                    bhi_reg <= bhi_src;
                end
            end
        end

        if (gi == LAST) begin : tail
            logic sa_reg;
            logic sb_reg;

            // Keep the operand signs (B un-inverted) for the overflow decision.
            always_ff @(posedge clk) begin
                if (rst) begin
                    sa_reg <= 1'b0;
                    sb_reg <= 1'b0;
                end else if (adv) begin
                    sa_reg <= gx[BLK-1];
                    sb_reg <= gy[BLK-1] ^ src_op[0];
                end
            end
        end
    end

    logic [WIDTH-1:0] raw_res;
    logic [1:0]       last_op;
    logic             sa;
    logic             sb;
    logic             ovf_raw;
    logic             sat_hit;

    assign raw_res   = stg[LAST].r_reg;
    assign last_op   = stg[LAST].op_reg;
    assign sa        = stg[LAST].tail.sa_reg;
    assign sb        = stg[LAST].tail.sb_reg;
    assign out_valid = stg[LAST].v_reg;
    assign cout      = stg[LAST].c_reg;

    // Signed overflow of the unsaturated result.
    assign ovf_raw = last_op[0] ? ((sa != sb) && (raw_res[WIDTH-1] != sa))
                                : ((sa == sb) && (raw_res[WIDTH-1] != sa));
    assign ovf     = ovf_raw;
    assign sat_hit = (SAT_EN != 0) && ((last_op == OP_ADDS) || (last_op == OP_SUBS)) && ovf_raw;

    // Clamp toward the sign of A on saturating overflow, else pass the raw sum.
    always_comb begin
        res = raw_res;
        if (sat_hit) begin
            res = sa ? RES_MIN : RES_MAX;
        end
    end

    // Zero is only meaningful for a valid beat, so it stays low out of reset.
    assign zero = out_valid && (res == '0);

endmodule
